// File: rtl/cdc_pulse_sync_multi.sv
// Multi-channel aclk->bclk pulse synchronizer: per-channel 4-phase req/ack with pending-pulse counter.
// Latency 1 aclk + SYNC_STAGES..SYNC_STAGES+1 bclk + 1 bclk; no backpressure, pulses beyond a saturated counter are dropped and flagged on a_ovf.
module cdc_pulse_sync_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3
) (
    input  logic          bclk,
    input  logic          rst,
    input  logic          aclk,
    input  logic [CH-1:0] a_pulse,
    input  logic [CH-1:0] a_ovf_clr,
    output logic [CH-1:0] a_busy,
    output logic [CH-1:0] a_ovf,
    output logic [CH-1:0] b_pulse
);

    // bit 0 of the state register is the req line itself, so req is a flop output
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] REQ  = 2'b01;
    localparam logic [1:0] ACKW = 2'b10;

    localparam logic [CNT_W:0] PMAX = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W:0] ONE  = {{CNT_W{1'b0}}, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [1:0]             state;
            logic [1:0]             state_nx;
            logic [CNT_W-1:0]       pend;
            logic [CNT_W-1:0]       pend_nx;
            logic [CNT_W:0]         total;
            logic [CNT_W:0]         total_m1;
            logic                   launch;
            logic                   drop;
            logic                   ovf_q;
            logic [SYNC_STAGES-1:0] ack_sync;
            logic                   ack_s;
            logic                   req;
            logic [SYNC_STAGES-1:0] req_sync;
            logic                   req_s;
            logic                   req_d;
            logic                   bp_q;

            assign req   = state[0];
            assign ack_s = ack_sync[SYNC_STAGES-1];
            assign req_s = req_sync[SYNC_STAGES-1];

            always_comb begin
                total    = {{CNT_W{1'b0}}, a_pulse[gi]} + {1'b0, pend};
                total_m1 = total - ONE;
                launch   = (state == IDLE) && (total != '0) && !ack_s;
                // a launching cycle consumes one pulse, so it can never overflow
                drop     = !launch && (total > PMAX);

                state_nx = state;
                case (state)
                    IDLE:    if (launch) state_nx = REQ;
                    REQ:     if (ack_s)  state_nx = ACKW;
                    ACKW:    if (!ack_s) state_nx = IDLE;
                    default: state_nx = IDLE;
                endcase

                if (launch)    pend_nx = total_m1[CNT_W-1:0];
                else if (drop) pend_nx = PMAX[CNT_W-1:0];
                else           pend_nx = total[CNT_W-1:0];
            end

            always_ff @(posedge aclk or negedge rst) begin
                if (!rst) begin
                    state    <= IDLE;
                    pend     <= '0;
                    ovf_q    <= 1'b0;
                    ack_sync <= '0;
                end else begin
                    state    <= state_nx;
                    pend     <= pend_nx;
                    ack_sync <= {ack_sync[SYNC_STAGES-2:0], req_s};
                    if (drop)                ovf_q <= 1'b1;
                    else if (a_ovf_clr[gi])  ovf_q <= 1'b0;
                end
            end

            always_ff @(posedge bclk or negedge rst) begin
                if (!rst) begin
                    req_sync <= '0;
                    req_d    <= 1'b0;
                    bp_q     <= 1'b0;
                end else begin
                    req_sync <= {req_sync[SYNC_STAGES-2:0], req};
                    req_d    <= req_s;
                    bp_q     <= req_s & ~req_d;
                end
            end

            assign a_busy[gi]  = (state != IDLE) | (pend != '0);
            assign a_ovf[gi]   = ovf_q;
            assign b_pulse[gi] = bp_q;
        end
    endgenerate

endmodule

// File: tb/tb_cdc_pulse_sync_multi.sv
// Scoreboard bench: two DUTs (default, and CNT_W=2/SYNC_STAGES=3) on shared, retunable clocks.
`timescale 1ns/1ps
module tb_cdc_pulse_sync_multi;
    localparam int CH = 4;

    logic    aclk = 1'b0;
    logic    bclk = 1'b0;
    logic    rst  = 1'b0;
    realtime a_half = 5.0;
    realtime b_half = 20.0;

    always #(a_half) aclk = ~aclk;
    always #(b_half) bclk = ~bclk;

    logic [CH-1:0] a_pulse_a = '0, a_ovf_clr_a = '0, a_busy_a, a_ovf_a, b_pulse_a;
    logic [CH-1:0] a_pulse_b = '0, a_ovf_clr_b = '0, a_busy_b, a_ovf_b, b_pulse_b;

    cdc_pulse_sync_multi #(.CH(CH), .SYNC_STAGES(2), .CNT_W(3)) dut_a (
        .bclk(bclk), .rst(rst), .aclk(aclk),
        .a_pulse(a_pulse_a), .a_ovf_clr(a_ovf_clr_a),
        .a_busy(a_busy_a), .a_ovf(a_ovf_a), .b_pulse(b_pulse_a)
    );

    cdc_pulse_sync_multi #(.CH(CH), .SYNC_STAGES(3), .CNT_W(2)) dut_b (
        .bclk(bclk), .rst(rst), .aclk(aclk),
        .a_pulse(a_pulse_b), .a_ovf_clr(a_ovf_clr_b),
        .a_busy(a_busy_b), .a_ovf(a_ovf_b), .b_pulse(b_pulse_b)
    );

    typedef struct {
        int     seq;
        longint deadline;
    } exp_t;

    // index 0..CH-1 = dut_a channels, CH..2*CH-1 = dut_b channels
    exp_t   sb[2*CH][$];
    int     tests = 0;
    int     fails = 0;
    int     seq   = 0;
    longint last_hi[2*CH];
    longint bcyc  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int idx, input longint dl);
        exp_t e;
        e.seq      = seq++;
        e.deadline = (dl == 0) ? 0 : longint'($time) + dl;
        sb[idx].push_back(e);
    endtask

    // one aclk cycle of stimulus; ea/eb mark which pulses must eventually be delivered
    task automatic drive(input logic [CH-1:0] pa, input logic [CH-1:0] ea,
                         input logic [CH-1:0] pb, input logic [CH-1:0] eb,
                         input longint dl);
        a_pulse_a = pa;
        a_pulse_b = pb;
        @(posedge aclk);
        for (int c = 0; c < CH; c++) begin
            if (ea[c]) push(c, dl);
            if (eb[c]) push(CH + c, dl);
        end
        #1;
        a_pulse_a   = '0;
        a_pulse_b   = '0;
        a_ovf_clr_a = '0;
        a_ovf_clr_b = '0;
    endtask

    function automatic bit sb_empty();
        for (int c = 0; c < 2*CH; c++)
            if (sb[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input int maxcyc);
        for (int i = 0; i < maxcyc; i++) begin
            @(posedge aclk);
            if (sb_empty() && a_busy_a == '0 && a_busy_b == '0) break;
        end
        repeat (12) @(posedge aclk);
        repeat (12) @(posedge bclk);
        #1;
        for (int c = 0; c < 2*CH; c++)
            check($sformatf("drain_q%0d", c), sb[c].size(), 0);
        check("drain_busy_a", a_busy_a, 0);
        check("drain_busy_b", a_busy_b, 0);
    endtask

    // monitor: every delivered pulse must match a queued expectation and keep >=2 low cycles between pulses
    always @(negedge bclk) begin
        logic v;
        exp_t e;
        bcyc++;
        for (int c = 0; c < 2*CH; c++) begin
            v = (c < CH) ? b_pulse_a[c] : b_pulse_b[c-CH];
            if (v) begin
                tests++;
                if (sb[c].size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse q%0d: got b_pulse=1 expected 0 at %0t", c, $time);
                end else begin
                    e = sb[c].pop_front();
                    if (e.deadline != 0) begin
                        tests++;
                        if (longint'($time) > e.deadline) begin
                            fails++;
                            $display("FAIL latency q%0d: got %0t expected <= %0d", c, $time, e.deadline);
                        end
                    end
                end
                tests++;
                if (bcyc - last_hi[c] < 3) begin
                    fails++;
                    $display("FAIL pulse_spacing q%0d: got gap %0d expected >= 3", c, bcyc - last_hi[c]);
                end
                last_hi[c] = bcyc;
            end
        end
    end

    initial begin
        for (int c = 0; c < 2*CH; c++) last_hi[c] = -100;

        // reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_busy_a", a_busy_a, 0);
        check("rst_ovf_a", a_ovf_a, 0);
        check("rst_bp_a", b_pulse_a, 0);
        check("rst_busy_b", a_busy_b, 0);
        check("rst_ovf_b", a_ovf_b, 0);
        check("rst_bp_b", b_pulse_b, 0);
        rst = 1'b1;
        repeat (4) @(posedge aclk);
        #1;

        // single pulse, 100/25 MHz, must arrive within 4 bclk
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0000, 160);
        check("t1_busy", a_busy_a[0], 1);
        wait_drain(600);

        // three back-to-back pulses on ch1
        drive(4'b0010, 4'b0010, '0, '0, 0);
        drive(4'b0010, 4'b0010, '0, '0, 0);
        drive(4'b0010, 4'b0010, '0, '0, 0);
        check("t2_busy", a_busy_a[1], 1);
        wait_drain(600);
        check("t2_ovf", a_ovf_a, 0);

        // saturation on dut_b ch2 (max 3 pending): 6 pulses -> 4 delivered
        for (int k = 0; k < 4; k++) drive('0, '0, 4'b0100, 4'b0100, 0);
        check("t3_ovf_pre", a_ovf_b, 0);
        drive('0, '0, 4'b0100, 4'b0000, 0);
        drive('0, '0, 4'b0100, 4'b0000, 0);
        check("t3_ovf_set", a_ovf_b, 4'b0100);
        wait_drain(600);
        check("t3_ovf_sticky", a_ovf_b, 4'b0100);
        a_ovf_clr_b = 4'b0100;
        @(posedge aclk);
        #1;
        a_ovf_clr_b = '0;
        check("t3_ovf_clr", a_ovf_b, 0);
        for (int k = 0; k < 4; k++) drive('0, '0, 4'b0100, 4'b0100, 0);
        a_ovf_clr_b = 4'b0100;
        drive('0, '0, 4'b0100, 4'b0000, 0);
        check("t3_set_beats_clr", a_ovf_b, 4'b0100);
        wait_drain(600);
        a_ovf_clr_b = 4'b0100;
        @(posedge aclk);
        #1;
        a_ovf_clr_b = '0;

        // all channels together, then staggered repeats: counts a=4/3/3/3
        drive(4'b1111, 4'b1111, 4'b1111, 4'b1111, 0);
        drive(4'b0101, 4'b0101, 4'b0101, 4'b0101, 0);
        drive(4'b0011, 4'b0011, 4'b0011, 4'b0011, 0);
        @(posedge aclk);
        #1;
        drive(4'b1000, 4'b1000, 4'b1000, 4'b1000, 0);
        drive(4'b1111, 4'b1111, 4'b1111, 4'b1111, 0);
        wait_drain(800);
        check("t4_ovf_a", a_ovf_a, 0);
        check("t4_ovf_b", a_ovf_b, 0);

        // reset mid-handshake with two pulses pending on ch0: nothing delivered
        drive(4'b0001, '0, '0, '0, 0);
        drive(4'b0001, '0, '0, '0, 0);
        drive(4'b0001, '0, '0, '0, 0);
        check("t5_busy_pre", a_busy_a[0], 1);
        rst = 1'b0;
        #2;
        check("t5_rst_busy_a", a_busy_a, 0);
        check("t5_rst_bp_a", b_pulse_a, 0);
        check("t5_rst_ovf_a", a_ovf_a, 0);
        check("t5_rst_busy_b", a_busy_b, 0);
        check("t5_rst_bp_b", b_pulse_b, 0);
        repeat (3) @(posedge aclk);
        #1;
        rst = 1'b1;
        repeat (60) @(posedge aclk);
        #1;
        check("t5_busy_post", a_busy_a, 0);
        drive(4'b0001, 4'b0001, '0, '0, 0);
        wait_drain(600);

        // reverse ratio: aclk 20 MHz, bclk 150 MHz, 5 spaced pulses on ch3
        a_half = 25.0;
        b_half = 3.333;
        repeat (4) @(posedge aclk);
        #1;
        for (int k = 0; k < 5; k++) begin
            drive(4'b1000, 4'b1000, 4'b1000, 4'b1000, 0);
            repeat (4) @(posedge aclk);
            #1;
        end
        wait_drain(600);
        check("t6_ovf_b", a_ovf_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdc_pulse_sync_multi.md
Name: cdc_pulse_sync_multi

Overview:
- Multi-channel pulse synchronizer from the aclk domain into the bclk domain.
- Uses a per-channel four-phase req/ack handshake, with the ack fed back from bclk to aclk.
- A per-channel pending counter queues pulses that arrive while a handshake is in flight, so back-to-back aclk pulses are not lost.
- Works for either clock ratio. Sits between control logic on a fast clock and consumers on a slower clock.

Parameters:
- CH, 4, number of independent pulse channels (>=1).
- SYNC_STAGES, 2, synchronizer flops per crossing direction (>=2).
- CNT_W, 3, width of the per-channel pending-pulse counter; max queued = 2^CNT_W-1.

Ports:
- bclk  input  1  destination clock.
- rst  input  1  reset, asynchronous, active-low; resets both domains.
- aclk  input  1  source clock.
- a_pulse  input  CH  per-channel single-cycle event, aclk domain.
- a_ovf_clr  input  CH  clears the matching a_ovf bit, aclk domain.
- a_busy  output  CH  channel has a handshake in flight or pulses pending, aclk domain.
- a_ovf  output  CH  sticky: a pulse was lost because the counter was saturated, aclk domain.
- b_pulse  output  CH  one-bclk-cycle event per delivered pulse, registered, bclk domain.

Behaviour:
- Reset is async, active-low. While rst=0, all flops in both domains are 0: req, ack synchronizers, req synchronizers, pend, FSM (=IDLE), a_ovf, b_pulse. Outputs are 0 during reset.
- Reset mid-handshake abandons all in-flight and pending pulses; nothing is delivered after release.
- Each channel is identical and independent. Nothing is shared except clocks and reset.
- aclk FSM per channel:
  - IDLE (req=0): if total>0 and ack_s==0 -> REQ.
  - REQ (req=1): wait for ack_s==1 -> ACKW.
  - ACKW (req=0): wait for ack_s==0 -> IDLE.
  - ack_s is the bclk-side synchronized req, passed back through SYNC_STAGES aclk flops.
  - req is a registered FSM output, never combinational.
- Pending counter per channel:
  - total = pend + a_pulse, computed at CNT_W+1 bits.
  - On the cycle IDLE->REQ: pend_next = total-1. A pulse arriving in IDLE with pend==0 launches directly; pend stays 0.
  - Otherwise pend_next = min(total, 2^CNT_W-1).
  - If total > 2^CNT_W-1: a_ovf set, and that pulse is dropped.
- a_ovf: set wins over a_ovf_clr in the same cycle. It is only cleared by a_ovf_clr or rst.
- a_busy = (state!=IDLE) | (pend!=0). It is registered-state derived and glitch-free within aclk.
- bclk side per channel:
  - req passes through SYNC_STAGES flops to give req_s, plus one delay flop req_d.
  - b_pulse registered = req_s & ~req_d: high exactly one bclk cycle per req rising edge.
  - req_s is the value returned as ack.
- Latency, a_pulse to b_pulse: 1 aclk + SYNC_STAGES..SYNC_STAGES+1 bclk + 1 bclk register.
- Per-pulse cycle time: about 2*(SYNC_STAGES+1) aclk + 2*(SYNC_STAGES+1) bclk. Bursts are delivered at that rate, in order, with count preserved.
- Consecutive b_pulses on one channel are always separated by >=2 bclk cycles low.
- a_pulse held high multiple aclk cycles counts as one pulse per cycle.

Test Plan:
- aclk 100 MHz, bclk 25 MHz, single a_pulse[0] -> exactly one b_pulse[0] of 1 bclk cycle within 4 bclk; a_busy[0] returns to 0 after handshake; other channels silent.
- 3 back-to-back a_pulse[1] cycles -> pend peaks at 2; exactly 3 b_pulse[1], each separated by >=2 bclk low; a_ovf[1]=0.
- CNT_W=2, 6 back-to-back a_pulse[2] -> first launches, pend saturates at 3, 2 dropped; exactly 4 b_pulse[2]; a_ovf[2]=1 until a_ovf_clr[2], then 0; set+clr in same cycle keeps 1.
- Simultaneous pulses on all CH channels, with staggered repeats -> per-channel b_pulse counts match per-channel a_pulse counts exactly.
- rst asserted while channel 0 is in REQ with pend=2 -> all outputs 0 immediately; after release no b_pulse[0] appears; a fresh pulse delivers normally.
- Reverse ratio (aclk 20 MHz, bclk 150 MHz), SYNC_STAGES=3, 5 pulses -> exactly 5 single-cycle b_pulses, none merged or duplicated.
